// File: rtl/nios2_c_gpio_in_multi_if.sv
// nios2_c_gpio_in_multi_if: Avalon-MM slave bus bundle for the multi-bit GPIO input port
interface nios2_c_gpio_in_multi_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    modport master(output address, chipselect, write_n, writedata, input readdata);
    modport slave(input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/nios2_c_gpio_in_multi.sv
// nios2_c_gpio_in_multi: debounced multi-bit input PIO with per-bit edge capture and IRQ mask
module nios2_c_gpio_in_multi #(
    parameter int       WIDTH    = 8,
    parameter int       DB_W     = 16,
    parameter bit       EDGE_RST = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    nios2_c_gpio_in_multi_if.slave  av,
    input  logic [WIDTH-1:0]        in_port,
    output logic                    irq
);
    logic [WIDTH-1:0] r_s1, r_s2, r_filt, r_rise_en, r_fall_en, r_mask, r_cap;
    logic [DB_W-1:0]  r_db;
    logic [DB_W-1:0]  r_cnt [WIDTH];
    logic [WIDTH-1:0] w_upd, w_set, w_wd, w_clr;
    logic [31:0]      w_rd;
    logic             w_wr;

    assign w_wr  = av.chipselect & ~av.write_n;
    assign w_wd  = av.writedata[WIDTH-1:0];
    assign w_clr = (w_wr && av.address == 3'd3) ? w_wd : '0;
    // Captures are ORed in after the clear so a simultaneous W1C never drops an event
    assign w_set = w_upd & ((r_s2 & ~r_filt & r_rise_en) | (~r_s2 & r_filt & r_fall_en));
    assign irq   = |(r_cap & r_mask);
    assign w_rd  = av.address == 3'd0 ? 32'(r_filt)    :
                   av.address == 3'd1 ? 32'(r_rise_en) :
                   av.address == 3'd2 ? 32'(r_mask)    :
                   av.address == 3'd3 ? 32'(r_cap)     :
                   av.address == 3'd4 ? 32'(r_fall_en) :
                   av.address == 3'd5 ? 32'(r_db)      : 32'd0;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign w_upd[i] = (r_s2[i] != r_filt[i]) && (r_cnt[i] == r_db);
        always_ff @(posedge clk) begin
            if (reset)
                r_cnt[i] <= '0;
            else
                r_cnt[i] <= ((w_wr && av.address == 3'd5) || r_s2[i] == r_filt[i] || w_upd[i])
                            ? '0 : r_cnt[i] + DB_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1        <= '0;
            r_s2        <= '0;
            r_filt      <= '0;
            r_rise_en   <= {WIDTH{EDGE_RST}};
            r_fall_en   <= {WIDTH{EDGE_RST}};
            r_mask      <= '0;
            r_cap       <= '0;
            r_db        <= '0;
            av.readdata <= '0;
        end else begin
            r_s1        <= in_port;
            r_s2        <= r_s1;
            r_filt      <= (r_filt & ~w_upd) | (r_s2 & w_upd);
            r_cap       <= (r_cap & ~w_clr) | w_set;
            av.readdata <= w_rd;
            if (w_wr && av.address == 3'd1) r_rise_en <= w_wd;
            if (w_wr && av.address == 3'd2) r_mask    <= w_wd;
            if (w_wr && av.address == 3'd4) r_fall_en <= w_wd;
            if (w_wr && av.address == 3'd5) r_db      <= av.writedata[DB_W-1:0];
        end
    end
endmodule
